// File: rtl/button_conditioner.sv
// button_conditioner
//   Conditions the four raw direction pushbuttons that feed the VGA
//   box-movement FSM. Each button is synchronised, debounced and auto-repeated
//   independently. A registered one-hot move strobe is then produced so the
//   display FSM steps exactly once per press or repeat.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive cycles of disagreement before a level flips (>=1)
//   REPEAT_DELAY     cycles from the first pulse to the first auto-repeat (>=2)
//   REPEAT_RATE      cycles between subsequent auto-repeats (>=2)
//
// Ports
//   clk        in   system clock, all logic on posedge
//   rst        in   asynchronous, active-high reset
//   up         in   raw pushbutton, asynchronous, active-high
//   down       in   raw pushbutton
//   left       in   raw pushbutton
//   right      in   raw pushbutton
//   dir_level  out  [3:0] debounced levels {right,left,down,up}
//   dir_pulse  out  [3:0] 1-cycle strobes per button on press and each repeat
//   move       out  [3:0] registered one-hot (or zero) step request {right,left,down,up}

module button_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned REPEAT_DELAY    = 50_000_000,
   parameter int unsigned REPEAT_RATE     = 10_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       up,
   input  logic       down,
   input  logic       left,
   input  logic       right,
   output logic [3:0] dir_level,
   output logic [3:0] dir_pulse,
   output logic [3:0] move
);

   localparam int unsigned NBTN   = 4;
   localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned RC_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int unsigned RC_W   = $clog2(RC_MAX);

   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [RC_W-1:0] RD_LAST = RC_W'(REPEAT_DELAY - 1);
   localparam logic [RC_W-1:0] RR_LAST = RC_W'(REPEAT_RATE - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_DELAY  = 2'b01,
      S_REPEAT = 2'b10
   } state_t;

   logic [3:0]      raw;
   logic [3:0]      sync1;
   logic [3:0]      s;
   logic [DB_W-1:0] db_cnt [NBTN];
   logic [RC_W-1:0] rc     [NBTN];
   state_t          state  [NBTN];

   assign raw = {right, left, down, up};

   // Two-flop synchroniser; s is the only copy the debouncer may look at.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= '0;
         s     <= '0;
      end else begin
         sync1 <= raw;
         s     <= sync1;
      end
   end

   // Debouncer: the level only follows s after DEBOUNCE_CYCLES consecutive
   // cycles of disagreement. Any agreement restarts the count, so short
   // glitches on press or release are discarded.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NBTN; i++) begin
            db_cnt[i] <= '0;
         end
         dir_level <= '0;
      end else begin
         for (int unsigned i = 0; i < NBTN; i++) begin
            if (s[i] == dir_level[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               dir_level[i] <= s[i];
               db_cnt[i]    <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   // Auto-repeat FSM per button. A release is checked before the terminal
   // count so a button let go on the same cycle never produces a late pulse
   // once the FSM sees the low level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NBTN; i++) begin
            state[i] <= S_IDLE;
            rc[i]    <= '0;
         end
         dir_pulse <= '0;
      end else begin
         dir_pulse <= '0;
         for (int unsigned i = 0; i < NBTN; i++) begin
            case (state[i])
               S_IDLE: begin
                  if (dir_level[i]) begin
                     dir_pulse[i] <= 1'b1;
                     rc[i]        <= '0;
                     state[i]     <= S_DELAY;
                  end
               end
               S_DELAY: begin
                  if (!dir_level[i]) begin
                     rc[i]    <= '0;
                     state[i] <= S_IDLE;
                  end else if (rc[i] == RD_LAST) begin
                     dir_pulse[i] <= 1'b1;
                     rc[i]        <= '0;
                     state[i]     <= S_REPEAT;
                  end else begin
                     rc[i] <= rc[i] + 1'b1;
                  end
               end
               S_REPEAT: begin
                  if (!dir_level[i]) begin
                     rc[i]    <= '0;
                     state[i] <= S_IDLE;
                  end else if (rc[i] == RR_LAST) begin
                     dir_pulse[i] <= 1'b1;
                     rc[i]        <= '0;
                  end else begin
                     rc[i] <= rc[i] + 1'b1;
                  end
               end
               default: begin
                  rc[i]    <= '0;
                  state[i] <= S_IDLE;
               end
            endcase
         end
      end
   end

   // Fixed-priority pick up > down > left > right; losers are dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         move <= '0;
      end else if (dir_pulse[0]) begin
         move <= 4'b0001;
      end else if (dir_pulse[1]) begin
         move <= 4'b0010;
      end else if (dir_pulse[2]) begin
         move <= 4'b0100;
      end else if (dir_pulse[3]) begin
         move <= 4'b1000;
      end else begin
         move <= '0;
      end
   end

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner
//   Self-checking bench for button_conditioner with small timing parameters.
//   Directed scenarios plus randomized bouncing/holding stimulus, compared
//   every cycle against a behavioural model built from the timing rules
//   (window of debouncer samples, pulse times computed from the rise edge).
//
// Ports: none (top-level bench).

module tb_button_conditioner;

   localparam int unsigned DB = 4;
   localparam int unsigned RD = 10;
   localparam int unsigned RR = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       up, down, left, right;
   logic [3:0] dir_level, dir_pulse, move;

   int unsigned tests = 0;
   int unsigned fails = 0;

   always #5 clk = ~clk;

   button_conditioner #(
      .DEBOUNCE_CYCLES (DB),
      .REPEAT_DELAY    (RD),
      .REPEAT_RATE     (RR)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .up        (up),
      .down      (down),
      .left      (left),
      .right     (right),
      .dir_level (dir_level),
      .dir_pulse (dir_pulse),
      .move      (move)
   );

   // Reference model state
   logic [3:0]  m_r1, m_r2;      // raw delayed by one / two edges
   logic [3:0]  m_level, m_pulse, m_move;
   logic [3:0]  win[$];          // last DB samples seen by the debouncer
   int unsigned rise_e [4];      // edge at which each level last rose
   int unsigned edge_no = 0;

   // Observed statistics for directed checks
   int unsigned pcnt [4];
   logic [3:0]  lvl_seen;

   function automatic logic [3:0] first_pulse(input logic [3:0] p);
      for (int k = 0; k < 4; k++) begin
         if (p[k]) return 4'b0001 << k;
      end
      return 4'b0000;
   endfunction

   // d = cycles since the first pulse was due
   function automatic bit pulse_due(input int unsigned d);
      if (d == 0) return 1'b1;
      if (d < RD) return 1'b0;
      return ((d - RD) % RR) == 0;
   endfunction

   task automatic model_reset();
      m_r1 = '0; m_r2 = '0;
      m_level = '0; m_pulse = '0; m_move = '0;
      win.delete();
   endtask

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %b expected %b (edge %0d)", tag, obs, exp, edge_no);
      end
   endtask

   task automatic set_btn(input logic [3:0] v);
      {right, left, down, up} = v;
   endtask

   task automatic clear_obs();
      for (int k = 0; k < 4; k++) pcnt[k] = 0;
      lvl_seen = '0;
   endtask

   // One clock edge: advance the model, then compare all outputs.
   task automatic tick();
      logic [3:0] raw_now, view, lvl_old;
      bit         all_diff;
      @(posedge clk);
      edge_no++;
      raw_now = {right, left, down, up};
      if (rst) begin
         model_reset();
      end else begin
         lvl_old = m_level;
         m_move  = first_pulse(m_pulse);
         for (int i = 0; i < 4; i++) begin
            m_pulse[i] = lvl_old[i] && pulse_due(edge_no - rise_e[i] - 1);
         end
         view = m_r2;
         m_r2 = m_r1;
         m_r1 = raw_now;
         win.push_back(view);
         if (win.size() > DB) void'(win.pop_front());
         if (win.size() == DB) begin
            for (int i = 0; i < 4; i++) begin
               all_diff = 1'b1;
               foreach (win[k]) if (win[k][i] == m_level[i]) all_diff = 1'b0;
               if (all_diff) begin
                  m_level[i] = ~m_level[i];
                  if (m_level[i]) rise_e[i] = edge_no;
               end
            end
         end
      end
      #1;
      check("dir_level", dir_level, m_level);
      check("dir_pulse", dir_pulse, m_pulse);
      check("move", move, m_move);
      for (int k = 0; k < 4; k++) pcnt[k] += int'(dir_pulse[k]);
      lvl_seen |= dir_level;
   endtask

   task automatic ticks(input int unsigned n);
      for (int unsigned k = 0; k < n; k++) tick();
   endtask

   // Called just after an edge: reset asynchronously, hold for n edges.
   task automatic do_reset(input int unsigned n);
      rst = 1'b1;
      #1;
      check("async_rst_level", dir_level, 4'b0000);
      check("async_rst_pulse", dir_pulse, 4'b0000);
      check("async_rst_move", move, 4'b0000);
      model_reset();
      ticks(n);
      rst = 1'b0;
   endtask

   initial begin
      int unsigned len;
      logic [3:0]  base, v;

      rst = 1'b1;
      set_btn(4'b0000);
      model_reset();
      ticks(3);
      check("reset_level", dir_level, 4'b0000);
      check("reset_pulse", dir_pulse, 4'b0000);
      check("reset_move", move, 4'b0000);
      rst = 1'b0;
      ticks(10);

      // Press and hold up for 40 cycles
      clear_obs();
      set_btn(4'b0001);
      ticks(5);
      check("t1_level_e5", dir_level, 4'b0000);
      tick();
      check("t1_level_e6", dir_level, 4'b0001);
      tick();
      check("t1_pulse_e7", dir_pulse, 4'b0001);
      check("t1_move_e7", move, 4'b0000);
      tick();
      check("t1_pulse_e8", dir_pulse, 4'b0000);
      check("t1_move_e8", move, 4'b0001);
      ticks(32);
      check("t3_pulse_count", 4'(pcnt[0]), 4'd9);
      set_btn(4'b0000);
      ticks(5);
      check("t3_level_held", dir_level, 4'b0001);
      tick();
      check("t3_level_fell", dir_level, 4'b0000);
      clear_obs();
      ticks(15);
      check("t3_no_pulse_after", 4'(pcnt[0]), 4'd0);

      // Short bounce is discarded
      clear_obs();
      set_btn(4'b0001);
      ticks(3);
      set_btn(4'b0000);
      ticks(20);
      check("t2_level_never", lvl_seen, 4'b0000);
      check("t2_no_pulse", 4'(pcnt[0]), 4'd0);

      // Simultaneous up and right
      set_btn(4'b1001);
      ticks(7);
      check("t4_pulse_e7", dir_pulse, 4'b1001);
      tick();
      check("t4_move_e8", move, 4'b0001);
      set_btn(4'b0000);
      ticks(20);

      // Reset mid S_DELAY with left held
      set_btn(4'b0100);
      ticks(12);
      do_reset(2);
      ticks(6);
      check("t5_pulse_e6", dir_pulse, 4'b0000);
      tick();
      check("t5_pulse_e7", dir_pulse, 4'b0100);
      set_btn(4'b0000);
      ticks(20);

      // Down released before the repeat delay expires
      clear_obs();
      set_btn(4'b0010);
      ticks(8);
      set_btn(4'b0000);
      ticks(20);
      check("t6_single_pulse", 4'(pcnt[1]), 4'd1);
      set_btn(4'b0010);
      ticks(7);
      check("t6_repress_e7", dir_pulse, 4'b0010);
      set_btn(4'b0000);
      ticks(20);

      // Randomized holds with occasional bounce and resets
      for (int seg = 0; seg < 60; seg++) begin
         len  = $urandom_range(1, 35);
         base = 4'($urandom_range(0, 15));
         for (int unsigned c = 0; c < len; c++) begin
            v = base;
            if ($urandom_range(0, 5) == 0) v = v ^ 4'($urandom_range(0, 15));
            set_btn(v);
            tick();
         end
         if ($urandom_range(0, 11) == 0) do_reset($urandom_range(1, 3));
      end
      set_btn(4'b0000);
      ticks(20);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
